// File: rtl/general_csr_init_master_pkg.sv
// Shared types for the general CSR bring-up master: register map, status bits,
// error codes and FSM encoding.
package general_csr_pkg;

  localparam logic [4:0] ADDR_SCRATCH = 5'h00;
  localparam logic [4:0] ADDR_STATUS  = 5'h04;

  localparam int RX_INIT = 21;
  localparam int TX_INIT = 22;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SCRATCH = 2'd1,
    ERR_INIT_TO = 2'd2,
    ERR_RSP_TO  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SCR,
    S_RD_SCR,
    S_WAIT_SCR,
    S_RD_STS,
    S_WAIT_STS,
    S_GAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/general_csr_init_master_if.sv
// Avalon-MM host-side bus between the bring-up master and the general CSR slave.
interface general_csr_init_master_if;
  logic [4:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/general_csr_init_master.sv
// Post-reset bring-up of the general CSR slave: scratch write/readback, then
// status polling until RX/TX init-done, with init and response timeouts.
module general_csr_init_master
  import general_csr_pkg::*;
#(
  parameter logic [4:0]  SCRATCH_ADDR    = ADDR_SCRATCH,
  parameter logic [4:0]  STATUS_ADDR     = ADDR_STATUS,
  parameter logic [31:0] SCRATCH_PATTERN = 32'hA5A5_5A5A,
  parameter int          POLL_GAP        = 16,
  parameter int          INIT_TIMEOUT    = 1_000_000,
  parameter int          RSP_TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] status_word,
  general_csr_init_master_if.master bus
);

  localparam int IW = $clog2(INIT_TIMEOUT + 1);
  localparam int RW = $clog2(RSP_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  localparam logic [IW-1:0] INIT_MAX = IW'(INIT_TIMEOUT);
  localparam logic [RW-1:0] RSP_MAX  = RW'(RSP_TIMEOUT);
  localparam logic [RW-1:0] RSP_LAST = RW'(RSP_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  state_e        state_q;
  logic          rd_q, wr_q, busy_q, done_q, pass_q;
  logic [4:0]    addr_q;
  logic [31:0]   wdata_q, sts_q;
  err_e          err_q;
  logic [IW-1:0] init_q, init_d;
  logic [RW-1:0] rsp_q, rsp_d;
  logic [GW-1:0] gap_q;
  logic          init_ok;

  assign init_ok = bus.readdata[TX_INIT] & bus.readdata[RX_INIT];

  // Both timers saturate so a long stall can never wrap them back under the limit.
  always_comb begin
    init_d = init_q;
    if ((state_q == S_RD_STS || state_q == S_WAIT_STS || state_q == S_GAP) &&
        init_q != INIT_MAX)
      init_d = init_q + 1'b1;
    rsp_d = rsp_q;
    if ((state_q == S_WAIT_SCR || state_q == S_WAIT_STS) && rsp_q != RSP_MAX)
      rsp_d = rsp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_NONE;
      sts_q   <= '0;
      init_q  <= '0;
      rsp_q   <= '0;
      gap_q   <= '0;
    end else begin
      init_q <= init_d;
      rsp_q  <= rsp_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_WR_SCR;
            wr_q    <= 1'b1;
            addr_q  <= SCRATCH_ADDR;
            wdata_q <= SCRATCH_PATTERN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= ERR_NONE;
          end
        end
        S_WR_SCR: begin
          if (!bus.waitrequest) begin
            state_q <= S_RD_SCR;
            wr_q    <= 1'b0;
            rd_q    <= 1'b1;
          end
        end
        S_RD_SCR, S_RD_STS: begin
          if (!bus.waitrequest) begin
            state_q <= (state_q == S_RD_SCR) ? S_WAIT_SCR : S_WAIT_STS;
            rd_q    <= 1'b0;
            rsp_q   <= '0;
          end
        end
        S_WAIT_SCR: begin
          if (bus.readdatavalid) begin
            if (bus.readdata == SCRATCH_PATTERN) begin
              state_q <= S_RD_STS;
              rd_q    <= 1'b1;
              addr_q  <= STATUS_ADDR;
              init_q  <= '0;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= ERR_SCRATCH;
            end
          end else if (rsp_q >= RSP_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= ERR_RSP_TO;
          end
        end
        S_WAIT_STS: begin
          // Data arriving on the expiry cycle takes priority over the response timeout.
          if (bus.readdatavalid) begin
            sts_q <= bus.readdata;
            if (init_ok) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else if (init_q >= INIT_MAX) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= ERR_INIT_TO;
            end else begin
              state_q <= S_GAP;
              gap_q   <= '0;
            end
          end else if (rsp_q >= RSP_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= ERR_RSP_TO;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_RD_STS;
            rd_q    <= 1'b1;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_code        = err_q;
  assign status_word     = sts_q;
  assign bus.address     = addr_q;
  assign bus.write       = wr_q;
  assign bus.read        = rd_q;
  assign bus.writedata   = wdata_q;
  assign bus.byteenable  = 4'hF;

endmodule

// File: tb/tb_general_csr_init_master.sv
// Randomized scoreboard bench for general_csr_init_master: a reactive Avalon
// slave, an outcome model computed per scenario, and a done-edge monitor.
module tb_general_csr_init_master;
  import general_csr_pkg::*;

  localparam int          PG  = 4;
  localparam int          IT  = 100;
  localparam int          RT  = 8;
  localparam logic [31:0] PAT = 32'hA5A5_5A5A;

  typedef struct {
    bit          corrupt;
    bit          never_set;
    bit          drop_scr;
    int          drop_sts;
    int          clear;
    int          lat;
    int          wr_stall;
    bit          rnd_wait;
    logic [31:0] sts_clr;
    logic [31:0] sts_set;
  } scn_t;

  typedef struct {
    bit          pass;
    logic [1:0]  err;
    logic [31:0] sw;
    int          nsts;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [1:0]  err_code;
  logic [31:0] status_word;

  general_csr_init_master_if bus();

  general_csr_init_master #(
    .POLL_GAP(PG), .INIT_TIMEOUT(IT), .RSP_TIMEOUT(RT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_code(err_code), .status_word(status_word), .bus(bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0, errors = 0;
  scn_t        cur;
  exp_t        exp_q[$];
  int          start_cyc, nsts, wr_cycles, drop_acc_cyc, done_seen = 0;
  logic [31:0] model_sw = '0;
  logic        done_prev = 1'b0;
  bit          pend = 0;
  int          pend_cyc;
  logic [31:0] pend_data;
  bit          in_txn = 0;
  int          stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic scn_t base_scn();
    scn_t s;
    s.corrupt = 0; s.never_set = 0; s.drop_scr = 0; s.drop_sts = -1;
    s.clear = 0; s.lat = 1; s.wr_stall = 0; s.rnd_wait = 0;
    s.sts_clr = 32'h0001_0000; s.sts_set = 32'h0061_1101;
    return s;
  endfunction

  // Outcome of a scenario from the behavioural rules; timing terms assume no stalls.
  function automatic exp_t predict(input scn_t s, input logic [31:0] prev_sw);
    exp_t e;
    int   k, p;
    e.pass = 0; e.err = 2'd0; e.sw = prev_sw; e.nsts = 0; e.lat = -1;
    p = 1 + s.lat + PG;
    if (s.drop_scr) begin
      e.err = 2'd3;
    end else if (s.corrupt) begin
      e.err = 2'd1; e.lat = 3 + s.lat;
    end else if (s.never_set) begin
      k = 0;
      while (k * p + s.lat < IT) k++;
      e.err = 2'd2; e.nsts = k + 1; e.sw = s.sts_clr; e.lat = 4 + 2 * s.lat + k * p;
    end else if (s.drop_sts >= 0) begin
      e.err = 2'd3; e.nsts = s.drop_sts + 1;
      if (s.drop_sts > 0) e.sw = s.sts_clr;
    end else begin
      e.pass = 1; e.nsts = s.clear + 1; e.sw = s.sts_set;
      e.lat = 4 + 2 * s.lat + s.clear * p;
    end
    if (s.wr_stall != 0 || s.rnd_wait) e.lat = -1;
    return e;
  endfunction

  // Reactive slave: stalls, latency, corruption and dropped responses per scenario.
  initial begin
    bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = '0;
    cur = base_scn();
    forever begin
      @(negedge clk);
      bus.readdatavalid = 1'b0;
      if (pend && cyc == pend_cyc) begin
        bus.readdatavalid = 1'b1; bus.readdata = pend_data; pend = 0;
      end
      if (!(bus.read || bus.write)) begin
        in_txn = 0;
        bus.waitrequest = cur.rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          stall = bus.write ? cur.wr_stall : (cur.rnd_wait ? int'($urandom_range(0, 2)) : 0);
        end
        if (bus.write) begin
          wr_cycles++;
          chk("write_addr", 32'(bus.address), 32'(ADDR_SCRATCH));
          chk("write_data", bus.writedata, PAT);
          chk("byteenable", 32'(bus.byteenable), 32'hF);
        end
        if (stall > 0) begin
          bus.waitrequest = 1'b1; stall--;
        end else begin
          bus.waitrequest = 1'b0; in_txn = 0;
          if (bus.read && bus.address == ADDR_SCRATCH) begin
            if (cur.drop_scr) drop_acc_cyc = cyc;
            else begin
              pend = 1; pend_cyc = cyc + cur.lat; pend_data = PAT ^ 32'(cur.corrupt);
            end
          end else if (bus.read) begin
            chk("status_addr", 32'(bus.address), 32'(ADDR_STATUS));
            if (nsts == cur.drop_sts) drop_acc_cyc = cyc;
            else begin
              pend = 1; pend_cyc = cyc + cur.lat;
              pend_data = (cur.never_set || nsts < cur.clear) ? cur.sts_clr : cur.sts_set;
            end
            nsts++;
          end
        end
      end
    end
  end

  // Monitor: on each rising done, pop the expected outcome and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        done_seen++;
        chk("exp_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pass", 32'(pass), 32'(e.pass));
          chk("err_code", 32'(err_code), 32'(e.err));
          chk("status_word", status_word, e.sw);
          chk("status_reads", 32'(nsts), 32'(e.nsts));
          chk("busy_at_done", 32'(busy), 32'd0);
          if (e.lat >= 0) chk("done_cycle", 32'(cyc - start_cyc), 32'(e.lat));
          if (e.err == 2'd3) chk("rsp_timeout_cycle", 32'(cyc - drop_acc_cyc), 32'(RT + 1));
        end
      end
      done_prev = done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"}, 32'(bus.read), 32'd0);
    chk({tag, "_write"}, 32'(bus.write), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_code), 32'd0);
    chk({tag, "_status"}, status_word, 32'd0);
    chk({tag, "_addr"}, 32'(bus.address), 32'd0);
    chk({tag, "_wdata"}, bus.writedata, 32'd0);
    chk({tag, "_be"}, 32'(bus.byteenable), 32'hF);
  endtask

  task automatic run(input scn_t s);
    exp_t e;
    int   n0, budget;
    @(negedge clk);
    cur = s; nsts = 0; wr_cycles = 0; drop_acc_cyc = -1000;
    e = predict(s, model_sw);
    model_sw = e.sw;
    exp_q.push_back(e);
    n0 = done_seen; start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    budget = 0;
    while (done_seen == n0 && budget < 3000) begin
      @(negedge clk);
      budget++;
      start = busy && ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    if (done_seen == n0) begin
      chk("done_within_budget", 32'(done_seen - n0), 32'd1);
      exp_q.delete();
      reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
      model_sw = '0;
    end
    if (s.wr_stall != 0) chk("write_hold_cycles", 32'(wr_cycles), 32'(s.wr_stall + 1));
  endtask

  task automatic reset_mid_run();
    scn_t s;
    int   budget;
    s = base_scn(); s.wr_stall = 5; s.clear = 3; s.lat = 6;
    @(negedge clk);
    cur = s; nsts = 0; wr_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (nsts == 0 && budget < 200) begin @(negedge clk); budget++; end
    chk("reset_run_first_poll", 32'(nsts), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    chk("reset_run_write_hold", 32'(wr_cycles), 32'd6);
    repeat (10) @(negedge clk);
    check_reset_outputs("late_rdv");
    model_sw = '0;
    cur = base_scn();
  endtask

  initial begin
    scn_t s;
    int   kind;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(base_scn());                                 // done at cycle 6, pass
    s = base_scn(); s.corrupt = 1; run(s);           // scratch mismatch
    s = base_scn(); s.clear = 3; s.sts_clr = 32'h0020_0F00; run(s);
    s = base_scn(); s.never_set = 1; s.sts_clr = 32'h0011_2233; run(s);
    s = base_scn(); s.drop_scr = 1; run(s);          // response timeout
    s = base_scn(); s.lat = RT; s.clear = 1; run(s); // data on expiry cycle wins
    reset_mid_run();

    for (int i = 0; i < 24; i++) begin
      s = base_scn();
      s.lat = $urandom_range(1, RT);
      s.rnd_wait = 1'($urandom_range(0, 1));
      s.wr_stall = $urandom_range(0, 3);
      s.clear = $urandom_range(0, 5);
      s.sts_set = $urandom | 32'h0060_0000;
      s.sts_clr = $urandom;
      if (s.sts_clr[TX_INIT] && s.sts_clr[RX_INIT]) s.sts_clr[$urandom_range(RX_INIT, TX_INIT)] = 1'b0;
      kind = $urandom_range(0, 9);
      case (kind)
        0: s.corrupt = 1;
        1: s.drop_scr = 1;
        2: s.drop_sts = $urandom_range(0, s.clear);
        3: begin s.never_set = 1; s.rnd_wait = 0; end
        default: ;
      endcase
      run(s);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
